// File: rtl/sdram_host_initiator.sv
// sdram_host_initiator: client-side issuer of READ/WRITE/REFRESH commands on the
// controller's cmd/cmdack port, with periodic refresh insertion, ack/data
// timeouts and a one-cycle completion pulse back to the client.
module sdram_host_initiator #(
  parameter int unsigned ASIZE       = 22,
  parameter int unsigned DSIZE       = 32,
  parameter int unsigned REF_PERIOD  = 1560,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [ASIZE-1:0] req_addr,
  input  logic [DSIZE-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DSIZE-1:0] rsp_rdata,
  output logic             err,
  output logic [1:0]       cmd,
  input  logic             cmdack,
  output logic [ASIZE-1:0] addr,
  output logic [DSIZE-1:0] wdata,
  input  logic             rd_valid,
  input  logic [DSIZE-1:0] rd_data
);

  localparam int unsigned RW = $clog2(REF_PERIOD);
  localparam int unsigned WW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_READ    = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_REFRESH = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DSIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             err_q, err_d;
  logic             ref_pending_q, ref_pending_d;
  logic [RW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             ref_clr;
  logic             ref_expire;
  logic             wait_expired;

  // Client may only hand over a request while idle with no refresh owed.
  assign req_ready = (state_q == S_IDLE) && !ref_pending_q;

  assign cmd       = cmd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;

  // Last permitted wait cycle: a cmdack/rd_valid seen here still wins.
  assign wait_expired = (wait_cnt_q == WW'(ACK_TIMEOUT - 1));

  // Command sequencing: next state, command bus and response generation.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    ref_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ref_pending_q) begin
          cmd_d      = CMD_REFRESH;
          wait_cnt_d = '0;
          state_d    = S_ISSUE;
        end else if (req_valid && req_ready) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          cmd_d      = req_wr ? CMD_WRITE : CMD_READ;
          wait_cnt_d = '0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        if (cmdack) begin
          cmd_d      = CMD_NOP;
          wait_cnt_d = '0;
          case (cmd_q)
            CMD_REFRESH: begin
              ref_clr = 1'b1;
              state_d = S_IDLE;
            end
            CMD_WRITE: state_d = S_DONE;
            default:   state_d = S_RD_WAIT;
          endcase
        end else if (wait_expired) begin
          err_d   = 1'b1;
          cmd_d   = CMD_NOP;
          ref_clr = (cmd_q == CMD_REFRESH);
          state_d = S_IDLE;
        end
      end

      S_RD_WAIT: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        if (rd_valid) begin
          rsp_rdata_d = rd_data;
          state_d     = S_DONE;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Refresh timer; an expiry on the clearing edge starts a fresh refresh, and
  // an expiry while one is already owed merges into it.
  always_comb begin
    ref_expire    = (ref_cnt_q == '0);
    ref_cnt_d     = ref_expire ? RW'(REF_PERIOD - 1) : ref_cnt_q - RW'(1);
    ref_pending_d = ref_expire | (ref_pending_q & ~ref_clr);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cmd_q         <= CMD_NOP;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      err_q         <= 1'b0;
      ref_pending_q <= 1'b0;
      ref_cnt_q     <= RW'(REF_PERIOD - 1);
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      err_q         <= err_d;
      ref_pending_q <= ref_pending_d;
      ref_cnt_q     <= ref_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_host_initiator.sv
// Bench for sdram_host_initiator: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a timeline model.
`timescale 1ns/1ps
module tb_sdram_host_initiator;

  localparam int unsigned ASIZE       = 22;
  localparam int unsigned DSIZE       = 32;
  localparam int unsigned REF_PERIOD  = 16;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_wr = 1'b0;
  logic [ASIZE-1:0] req_addr = '0;
  logic [DSIZE-1:0] req_wdata = '0;
  logic             rsp_valid;
  logic [DSIZE-1:0] rsp_rdata;
  logic             err;
  logic [1:0]       cmd;
  logic             cmdack = 1'b0;
  logic [ASIZE-1:0] addr;
  logic [DSIZE-1:0] wdata;
  logic             rd_valid = 1'b0;
  logic [DSIZE-1:0] rd_data = '0;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  sdram_host_initiator #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .REF_PERIOD(REF_PERIOD), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
    .cmd(cmd), .cmdack(cmdack), .addr(addr), .wdata(wdata),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // ---------------- timeline model ----------------
  typedef enum int {P_IDLE, P_CMD, P_RD, P_DONE} ph_e;
  ph_e              ph = P_IDLE;
  int unsigned      k = 0;       // clock edges since reset release
  int unsigned      t0 = 0;      // edge at which the current wait began
  int unsigned      el;
  bit               pend = 1'b0;
  bit               clr;
  logic [1:0]       m_cmd = 2'b00;
  logic [ASIZE-1:0] m_addr = '0;
  logic [DSIZE-1:0] m_wdata = '0;
  logic [DSIZE-1:0] m_rdata = '0;
  bit               m_rsp = 1'b0;
  bit               m_err = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = P_IDLE; k = 0; t0 = 0; pend = 1'b0;
      m_cmd = 2'b00; m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_rsp = 1'b0; m_err = 1'b0;
    end else begin
      k++;
      clr   = 1'b0;
      el    = k - t0;
      m_rsp = (ph == P_DONE);
      case (ph)
        P_IDLE: begin
          if (pend) begin
            m_cmd = 2'b11; ph = P_CMD; t0 = k;
          end else if (req_valid) begin
            m_addr = req_addr; m_wdata = req_wdata;
            m_cmd = req_wr ? 2'b10 : 2'b01; ph = P_CMD; t0 = k;
          end
        end
        P_CMD: begin
          if (cmdack) begin
            clr = (m_cmd == 2'b11);
            if (m_cmd == 2'b11)      ph = P_IDLE;
            else if (m_cmd == 2'b10) ph = P_DONE;
            else                     ph = P_RD;
            m_cmd = 2'b00; t0 = k;
          end else if (el >= ACK_TIMEOUT) begin
            clr = (m_cmd == 2'b11);
            m_err = 1'b1; m_cmd = 2'b00; ph = P_IDLE;
          end
        end
        P_RD: begin
          if (rd_valid) begin
            m_rdata = rd_data; ph = P_DONE;
          end else if (el >= ACK_TIMEOUT) begin
            m_err = 1'b1; ph = P_IDLE;
          end
        end
        default: ph = P_IDLE;
      endcase
      if ((k % REF_PERIOD) == 0) pend = 1'b1;
      else if (clr)              pend = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd",       64'(cmd),       64'(m_cmd));
      chk("addr",      64'(addr),      64'(m_addr));
      chk("wdata",     64'(wdata),     64'(m_wdata));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      chk("err",       64'(err),       64'(m_err));
      chk("req_ready", 64'(req_ready), 64'((ph == P_IDLE) && !pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 1'b0; cmdack = 1'b0; rd_valid = 1'b0;
    #1;
    cmp_en = 1'b1;
    chk("rst_cmd",       64'(cmd),       64'(0));
    chk("rst_addr",      64'(addr),      64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err",       64'(err),       64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int          n_ref;
  int unsigned ack_den;

  initial begin
    #2;
    // Write, cmdack three cycles after the command appears.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 22'h001234; req_wdata = 32'hDEADBEEF;
    tick();                                           // edge 1: accepted
    req_valid = 1'b0;
    chk("wr_cmd1", 64'(cmd), 64'(2));
    chk("wr_addr1", 64'(addr), 64'(22'h001234));
    chk("wr_wdata1", 64'(wdata), 64'(32'hDEADBEEF));
    tick();
    chk("wr_cmd2", 64'(cmd), 64'(2));
    tick();
    chk("wr_cmd3", 64'(cmd), 64'(2));
    chk("wr_wdata3", 64'(wdata), 64'(32'hDEADBEEF));
    cmdack = 1'b1;
    tick();                                           // edge 4: acked
    cmdack = 1'b0;
    chk("wr_nop", 64'(cmd), 64'(0));
    chk("wr_rsp_early", 64'(rsp_valid), 64'(0));
    tick();
    chk("wr_rsp", 64'(rsp_valid), 64'(1));
    chk("wr_err", 64'(err), 64'(0));
    tick();
    chk("wr_rsp_once", 64'(rsp_valid), 64'(0));

    // Read at top address: ack after 1 cycle, data 4 cycles later.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 22'h3FFFFF;
    tick();                                           // edge 7
    req_valid = 1'b0;
    chk("rd_cmd", 64'(cmd), 64'(1));
    chk("rd_addr", 64'(addr), 64'(22'h3FFFFF));
    cmdack = 1'b1;
    tick();                                           // edge 8
    cmdack = 1'b0;
    chk("rd_nop", 64'(cmd), 64'(0));
    repeat (3) tick();
    rd_valid = 1'b1; rd_data = 32'hA5A55A5A;
    tick();                                           // edge 12
    rd_valid = 1'b0;
    chk("rd_rsp_early", 64'(rsp_valid), 64'(0));
    tick();
    chk("rd_rsp", 64'(rsp_valid), 64'(1));
    chk("rd_rdata", 64'(rsp_rdata), 64'(32'hA5A55A5A));
    tick();
    chk("rd_rsp_once", 64'(rsp_valid), 64'(0));
    tick();                                           // edge 15
    chk("ref_ready_before", 64'(req_ready), 64'(1));
    tick();                                           // edge 16: expiry
    chk("ref_ready_low", 64'(req_ready), 64'(0));
    tick();
    chk("ref_cmd", 64'(cmd), 64'(3));
    cmdack = 1'b1;
    tick();
    cmdack = 1'b0;
    chk("ref_nop", 64'(cmd), 64'(0));
    chk("ref_ready_back", 64'(req_ready), 64'(1));

    // Write with no cmdack: timeout after ACK_TIMEOUT cycles.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 22'h0ABCDE; req_wdata = 32'h12345678;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();                                // edge 8
    chk("to_cmd_held", 64'(cmd), 64'(2));
    chk("to_err_early", 64'(err), 64'(0));
    tick();                                           // edge 9
    chk("to_err", 64'(err), 64'(1));
    chk("to_nop", 64'(cmd), 64'(0));
    tick();
    chk("to_no_rsp", 64'(rsp_valid), 64'(0));
    chk("to_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 22'h000055;
    tick();
    req_valid = 1'b0;
    chk("to_next_cmd", 64'(cmd), 64'(1));
    cmdack = 1'b1;
    tick();
    cmdack = 1'b0; rd_valid = 1'b1; rd_data = 32'h0BADF00D;
    tick();
    rd_valid = 1'b0;
    tick();
    chk("to_next_rsp", 64'(rsp_valid), 64'(1));
    chk("to_next_rdata", 64'(rsp_rdata), 64'(32'h0BADF00D));
    chk("to_err_sticky", 64'(err), 64'(1));

    // cmdack on the last allowed cycle wins over timeout; spurious pulses in IDLE.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 22'h000777; req_wdata = 32'h00C0FFEE;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    cmdack = 1'b1;
    tick();                                           // edge 8
    cmdack = 1'b0;
    chk("race_nop", 64'(cmd), 64'(0));
    chk("race_err", 64'(err), 64'(0));
    tick();
    chk("race_rsp", 64'(rsp_valid), 64'(1));
    cmdack = 1'b1; rd_valid = 1'b1; rd_data = 32'hFFFFFFFF;
    tick();
    cmdack = 1'b0; rd_valid = 1'b0;
    tick();
    chk("spur_cmd", 64'(cmd), 64'(0));
    chk("spur_rsp", 64'(rsp_valid), 64'(0));
    chk("spur_rdata", 64'(rsp_rdata), 64'(0));
    chk("spur_ready", 64'(req_ready), 64'(1));

    // Reset in RD_WAIT, then a clean read and a restarted refresh timer.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 22'h2AAAAA;
    tick();
    req_valid = 1'b0; cmdack = 1'b1;
    tick();
    cmdack = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd", 64'(cmd), 64'(0));
    chk("mid_rst_addr", 64'(addr), 64'(0));
    chk("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    tick();
    reset_n = 1'b1;
    req_valid = 1'b1; req_addr = 22'h155555;
    tick();                                           // edge 1
    req_valid = 1'b0; cmdack = 1'b1;
    tick();
    cmdack = 1'b0; rd_valid = 1'b1; rd_data = 32'hCAFEF00D;
    tick();
    rd_valid = 1'b0;
    tick();                                           // edge 4
    chk("post_rst_rsp", 64'(rsp_valid), 64'(1));
    chk("post_rst_rdata", 64'(rsp_rdata), 64'(32'hCAFEF00D));
    repeat (11) tick();                               // edge 15
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    tick();                                           // edge 16
    chk("post_rst_ref", 64'(req_ready), 64'(0));

    // req_valid held high: exactly one REFRESH per period over 205 cycles.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; cmdack = 1'b1; rd_valid = 1'b1;
    n_ref = 0;
    for (int c = 0; c < 205; c++) begin
      req_addr = ASIZE'($urandom); req_wdata = $urandom;
      tick();
      if (cmd == 2'b11) n_ref++;
    end
    chk("ref_count", 64'(n_ref), 64'(12));

    // Randomized traffic with varying ack probability and occasional resets.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      ack_den = (blk % 2 == 0) ? 2 : 9;
      for (int c = 0; c < 500; c++) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_wr    = ($urandom_range(0, 1) == 1);
        req_addr  = ASIZE'($urandom);
        req_wdata = $urandom;
        cmdack    = ($urandom_range(0, ack_den - 1) == 0);
        rd_valid  = ($urandom_range(0, ack_den - 1) == 0);
        rd_data   = $urandom;
        if ($urandom_range(0, 699) == 0) begin
          reset_n = 1'b0;
          tick();
          reset_n = 1'b1;
        end else begin
          tick();
        end
      end
    end
    req_valid = 1'b0; cmdack = 1'b0; rd_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
